// File: rtl/binop_pkg.sv
// Shared types and helpers for the sequential binary-operator ALU.
// Exports op_t (opcode encoding), state_t (control FSM states), wide_t
// (scratch width for intermediate results) and sat_trunc (clamp to N bits).
package binop_pkg;

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_XOR, OP_SHL, OP_SHR
  } op_t;

  typedef enum logic [1:0] {ST_IDLE, ST_DIV, ST_DONE} state_t;

  // Intermediate results are formed at this width, then cut down to NOUT.
  // It covers a 2*NW product for operands up to 32 bits wide.
  localparam int RW = 64;
  typedef logic [RW-1:0] wide_t;

  // Clamp value to the largest number representable in nout bits.
  function automatic wide_t sat_trunc(input wide_t value, input int nout);
    wide_t lim;
    if (nout >= RW) lim = '1;
    else            lim = (wide_t'(1) << nout) - wide_t'(1);
    return (value > lim) ? lim : value;
  endfunction

endpackage

// File: rtl/binop_seq_alu_if.sv
// Operand/result handshake bundle for binop_seq_alu.
// Request side: in_valid/in_ready, op, a, b.
// Response side: out_valid/out_ready, xout, div0. slave = ALU view, master = producer/consumer view.
interface binop_seq_alu_if
  import binop_pkg::*;
#(
  parameter int NA   = 8,
  parameter int NB   = 16,
  parameter int NOUT = 16
);
  logic            in_valid;
  logic            in_ready;
  op_t             op;
  logic [NA-1:0]   a;
  logic [NB-1:0]   b;
  logic            out_valid;
  logic            out_ready;
  logic [NOUT-1:0] xout;
  logic            div0;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, xout, div0
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, xout, div0
  );
endinterface

// File: rtl/binop_divider.sv
// Iterative restoring divider, one quotient bit per cycle, NW cycles per operation.
// Ports: start/dividend/divisor in; busy, done (results valid), quot, rem out.
// The first bit is produced on the start edge itself. A zero divisor yields all-ones quotient, remainder = dividend.
module binop_divider #(
  parameter int NW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [NW-1:0] dividend,
  input  logic [NW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] quot,
  output logic [NW-1:0] rem
);
  localparam int CW = $clog2(NW) + 1;

  logic [NW-1:0] rem_q, quot_q, dsr_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;

  logic [NW-1:0] src_rem, src_quot, src_dsr, nxt_rem, nxt_quot;
  logic [NW:0]   partial, trial;
  logic          fits, step;

  // On the start edge the step works straight from the incoming operands,
  // so only NW-1 further steps are needed after it.
  always_comb begin
    src_rem  = start ? '0       : rem_q;
    src_quot = start ? dividend : quot_q;
    src_dsr  = start ? divisor  : dsr_q;
    partial  = {src_rem, src_quot[NW-1]};
    trial    = partial - {1'b0, src_dsr};
    fits     = !trial[NW];
    nxt_rem  = fits ? trial[NW-1:0] : partial[NW-1:0];
    nxt_quot = {src_quot[NW-2:0], fits};
  end

  assign step = start || (busy_q && (cnt_q != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quot_q <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      if (step) begin
        rem_q  <= nxt_rem;
        quot_q <= nxt_quot;
      end
      if (start) begin
        dsr_q  <= divisor;
        cnt_q  <= CW'(NW - 1);
        busy_q <= 1'b1;
      end else if (busy_q && (cnt_q != '0)) begin
        cnt_q  <= cnt_q - 1'b1;
      end else if (busy_q) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == '0);
  assign quot = quot_q;
  assign rem  = rem_q;
endmodule

// File: rtl/binop_seq_alu.sv
// Clocked unsigned ALU: ADD/SUB/MUL/XOR/SHL/SHR in one cycle, DIV/MOD via iterative divider (NW+1 cycles).
// Ports: clk, rst_n (async active-low); bus.slave carries in_valid/in_ready/op/a/b and out_valid/out_ready/xout/div0.
// Result held until out_ready; a new op is accepted in the same cycle as the result drains. Macro BINOP_SAT_EN: saturate ADD/SUB/MUL.
module binop_seq_alu
  import binop_pkg::*;
#(
  parameter int NA   = 8,
  parameter int NB   = 16,
  parameter int NOUT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  binop_seq_alu_if.slave bus
);
  localparam int    NW       = (NA > NB) ? NA : NB;
  localparam int    SW       = $clog2(NW) + 1;
  localparam wide_t NW_MASK  = (wide_t'(1) << NW) - wide_t'(1);
  localparam wide_t NW1_MASK = (wide_t'(1) << (NW + 1)) - wide_t'(1);

  state_t          state, state_d;
  op_t             op_q;
  logic            bz_q;
  logic            div0_q, div0_d;
  logic [NOUT-1:0] xout_q, xout_d, op_xout, div_res;
  logic [NW-1:0]   a_ext, b_ext, quot, rem;
  wide_t           aw, bw, op_res;
  logic            accept, start, div_busy, div_done;

  assign a_ext = NW'(bus.a);
  assign b_ext = NW'(bus.b);
  assign aw    = wide_t'(a_ext);
  assign bw    = wide_t'(b_ext);

  // The divider busy term is redundant with the DIV state; it keeps a new
  // division from ever restarting a divider that has not yet drained.
  assign bus.in_ready = ((state == ST_IDLE) || (state == ST_DONE && bus.out_ready)) && !div_busy;
  assign accept       = bus.in_valid && bus.in_ready;
  assign start        = accept && (bus.op == OP_DIV || bus.op == OP_MOD);

  binop_divider #(.NW(NW)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (a_ext),
    .divisor  (b_ext),
    .busy     (div_busy),
    .done     (div_done),
    .quot     (quot),
    .rem      (rem)
  );

  // Single-cycle operations, evaluated on the accepting edge.
  always_comb begin
    op_res = '0;
    case (bus.op)
      OP_ADD:  op_res = aw + bw;
      OP_SUB:  op_res = (aw - bw) & NW1_MASK;
      OP_MUL:  op_res = aw * bw;
      OP_XOR:  op_res = aw ^ bw;
      OP_SHL:  op_res = (bw >= wide_t'(NW)) ? '0 : ((aw << b_ext[SW-1:0]) & NW_MASK);
      OP_SHR:  op_res = (bw >= wide_t'(NW)) ? '0 : (aw >> b_ext[SW-1:0]);
      default: op_res = '0;
    endcase
`ifdef BINOP_SAT_EN
    if (bus.op == OP_ADD || bus.op == OP_MUL) op_res = sat_trunc(op_res, NOUT);
    if (bus.op == OP_SUB) op_res = (bw > aw) ? '0 : sat_trunc(aw - bw, NOUT);
`endif
    op_xout = NOUT'(op_res);
  end

  always_comb begin
    div_res = NOUT'(rem);
    if (op_q == OP_DIV) div_res = bz_q ? '1 : NOUT'(quot);
  end

  always_comb begin
    state_d = state;
    xout_d  = xout_q;
    div0_d  = div0_q;
    case (state)
      ST_IDLE: ;
      ST_DIV: begin
        if (div_done) begin
          state_d = ST_DONE;
          xout_d  = div_res;
          div0_d  = bz_q;
        end
      end
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // An accept in DONE overrides the drain to IDLE.
    if (accept) begin
      if (start) begin
        state_d = ST_DIV;
      end else begin
        state_d = ST_DONE;
        xout_d  = op_xout;
        div0_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      xout_q <= '0;
      div0_q <= 1'b0;
      op_q   <= OP_ADD;
      bz_q   <= 1'b0;
    end else begin
      state  <= state_d;
      xout_q <= xout_d;
      div0_q <= div0_d;
      if (start) begin
        op_q <= bus.op;
        bz_q <= (b_ext == '0);
      end
    end
  end

  assign bus.out_valid = (state == ST_DONE);
  assign bus.xout      = xout_q;
  assign bus.div0      = div0_q;
endmodule

// File: tb/tb_binop_seq_alu.sv
// Self-checking bench for binop_seq_alu (NA=8, NB=16, NOUT=16).
// Directed scenarios plus randomized ops against an arithmetic reference model.
// Honours BINOP_SAT_EN the same way as the design build.
module tb_binop_seq_alu;
  import binop_pkg::*;

  localparam int NA = 8, NB = 16, NOUT = 16, NW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  binop_seq_alu_if #(.NA(NA), .NB(NB), .NOUT(NOUT)) bus ();

  binop_seq_alu #(.NA(NA), .NB(NB), .NOUT(NOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Reference: returns {div0, xout} from the arithmetic rules directly.
  function automatic logic [NOUT:0] ref_model(input op_t op, input longint unsigned a,
                                               input longint unsigned b);
    longint unsigned lim, r;
    logic dz;
    lim = (64'd1 << NOUT) - 1;
    r   = 0;
    dz  = 1'b0;
    case (op)
      OP_ADD: r = a + b;
      OP_SUB: r = (a >= b) ? a - b : (64'd1 << (NW + 1)) + a - b;
      OP_MUL: r = a * b;
      OP_DIV: if (b == 0) begin r = lim; dz = 1'b1; end else r = a / b;
      OP_MOD: if (b == 0) begin r = a;   dz = 1'b1; end else r = a % b;
      OP_XOR: r = a ^ b;
      OP_SHL: r = (b >= NW) ? 0 : (a << b) % (64'd1 << NW);
      OP_SHR: r = (b >= NW) ? 0 : a >> b;
      default: r = 0;
    endcase
`ifdef BINOP_SAT_EN
    if (op == OP_ADD || op == OP_MUL) r = (r > lim) ? lim : r;
    if (op == OP_SUB) r = (b > a) ? 0 : ((r > lim) ? lim : r);
`endif
    return {dz, r[NOUT-1:0]};
  endfunction

  // Issue one op, wait (bounded) for its result. lat = cycles from accept edge
  // to out_valid; rdy_low stays 1 only if in_ready was 0 while waiting.
  task automatic run_op(input op_t op, input logic [NA-1:0] a, input logic [NB-1:0] b,
                        output logic [NOUT-1:0] x, output logic dz, output int lat,
                        output bit rdy_low);
    int guard;
    @(negedge clk);
    bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1; rdy_low = 1'b1;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) rdy_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    x = bus.xout; dz = bus.div0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.op = OP_ADD; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({bus.out_valid, bus.div0, bus.xout} !== {1'b0, 1'b0, 16'h0000})
      $display("FAIL reset_outputs: got v=%b d=%b x=%h want 0 0 0000", bus.out_valid, bus.div0, bus.xout);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_add();
    logic [NOUT-1:0] x; logic dz; int lat; bit rl;
    run_op(OP_ADD, 8'hF0, 16'h0020, x, dz, lat, rl);
    n_total++;
    if ({dz, x} !== {1'b0, 16'h0110}) $display("FAIL add_basic: got d=%b x=%h want 0 0110", dz, x);
    else n_pass++;
    n_total++;
    if (lat !== 1) $display("FAIL add_latency: got %0d want 1", lat);
    else n_pass++;
  endtask

  task automatic test_wrap_sat();
    logic [NOUT-1:0] x, exp_add, exp_sub; logic dz; int lat; bit rl;
`ifdef BINOP_SAT_EN
    exp_add = 16'hFFFF; exp_sub = 16'h0000;
`else
    exp_add = 16'h00FE; exp_sub = 16'hFFFF;
`endif
    run_op(OP_ADD, 8'hFF, 16'hFFFF, x, dz, lat, rl);
    n_total++;
    if (x !== exp_add) $display("FAIL add_overflow: got %h want %h", x, exp_add);
    else n_pass++;
    run_op(OP_SUB, 8'd1, 16'd2, x, dz, lat, rl);
    n_total++;
    if (x !== exp_sub) $display("FAIL sub_underflow: got %h want %h", x, exp_sub);
    else n_pass++;
  endtask

  task automatic test_div();
    logic [NOUT-1:0] x; logic dz; int lat; bit rl;
    run_op(OP_DIV, 8'd200, 16'd7, x, dz, lat, rl);
    n_total++;
    if ({dz, x} !== {1'b0, 16'd28}) $display("FAIL div_quot: got d=%b x=%0d want 0 28", dz, x);
    else n_pass++;
    n_total++;
    if (lat !== NW + 1) $display("FAIL div_latency: got %0d want %0d", lat, NW + 1);
    else n_pass++;
    n_total++;
    if (rl !== 1'b1) $display("FAIL div_in_ready_low: in_ready seen high during divide");
    else n_pass++;
    run_op(OP_MOD, 8'd200, 16'd7, x, dz, lat, rl);
    n_total++;
    if ({dz, x, lat} !== {1'b0, 16'd4, NW + 1}) $display("FAIL mod_rem: got d=%b x=%0d lat=%0d want 0 4 17", dz, x, lat);
    else n_pass++;
  endtask

  task automatic test_div0();
    logic [NOUT-1:0] x; logic dz; int lat; bit rl;
    run_op(OP_DIV, 8'd5, 16'd0, x, dz, lat, rl);
    n_total++;
    if ({dz, x, lat} !== {1'b1, 16'hFFFF, NW + 1}) $display("FAIL div_by_zero: got d=%b x=%h lat=%0d want 1 ffff 17", dz, x, lat);
    else n_pass++;
    run_op(OP_MOD, 8'd5, 16'd0, x, dz, lat, rl);
    n_total++;
    if ({dz, x, lat} !== {1'b1, 16'd5, NW + 1}) $display("FAIL mod_by_zero: got d=%b x=%h lat=%0d want 1 0005 17", dz, x, lat);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.out_ready = 1'b1; bus.op = OP_MUL; bus.a = 8'd3; bus.b = 16'd5; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if ({bus.out_valid, bus.xout} !== {1'b1, 16'd15}) $display("FAIL b2b_mul: got v=%b x=%h want 1 000f", bus.out_valid, bus.xout);
    else n_pass++;
    bus.op = OP_SHL; bus.a = 8'd1; bus.b = 16'd15;
    @(posedge clk); #1;
    n_total++;
    if ({bus.out_valid, bus.xout} !== {1'b1, 16'h8000}) $display("FAIL b2b_shl: got v=%b x=%h want 1 8000", bus.out_valid, bus.xout);
    else n_pass++;
    bus.op = OP_SHR; bus.a = 8'd1; bus.b = 16'd16;
    @(posedge clk); #1;
    n_total++;
    if ({bus.out_valid, bus.xout} !== {1'b1, 16'h0000}) $display("FAIL b2b_shr: got v=%b x=%h want 1 0000", bus.out_valid, bus.xout);
    else n_pass++;
    bus.op = OP_XOR; bus.a = 8'hA5; bus.b = 16'h0F0F;
    @(posedge clk); #1;
    n_total++;
    if ({bus.out_valid, bus.xout} !== {1'b1, 16'h0FAA}) $display("FAIL b2b_xor: got v=%b x=%h want 1 0faa", bus.out_valid, bus.xout);
    else n_pass++;
    // Stall the consumer with the next op already offered.
    bus.out_ready = 1'b0; bus.op = OP_ADD; bus.a = 8'd2; bus.b = 16'd3;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_total++;
      if ({bus.out_valid, bus.in_ready, bus.xout} !== {1'b1, 1'b0, 16'h0FAA})
        $display("FAIL stall_hold_%0d: got v=%b r=%b x=%h want 1 0 0faa", i, bus.out_valid, bus.in_ready, bus.xout);
      else n_pass++;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_total++;
    if ({bus.out_valid, bus.xout} !== {1'b1, 16'd5}) $display("FAIL stall_release: got v=%b x=%h want 1 0005", bus.out_valid, bus.xout);
    else n_pass++;
  endtask

  task automatic test_reset_mid_div();
    logic [NOUT-1:0] x; logic dz; int lat; bit rl; int seen;
    @(negedge clk);
    bus.op = OP_DIV; bus.a = 8'd200; bus.b = 16'd7; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus.out_valid, bus.xout} !== {1'b0, 16'h0000}) $display("FAIL mid_div_reset: got v=%b x=%h want 0 0000", bus.out_valid, bus.xout);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (bus.out_valid) seen++; end
    n_total++;
    if (seen !== 0) $display("FAIL mid_div_discard: got %0d valid cycles want 0", seen);
    else n_pass++;
    run_op(OP_ADD, 8'd2, 16'd3, x, dz, lat, rl);
    n_total++;
    if ({dz, x, lat} !== {1'b0, 16'd5, 1}) $display("FAIL post_reset_add: got d=%b x=%h lat=%0d want 0 0005 1", dz, x, lat);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [NOUT-1:0] x; logic dz; int lat, exp_lat; bit rl;
    logic [NA-1:0] a; logic [NB-1:0] b; op_t op; logic [NOUT:0] exp;
    for (int i = 0; i < 150; i++) begin
      op = op_t'($urandom_range(0, 7));
      a  = NA'($urandom);
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = NB'($urandom_range(0, 20));
        default: b = NB'($urandom);
      endcase
      exp     = ref_model(op, longint'(a), longint'(b));
      exp_lat = (op == OP_DIV || op == OP_MOD) ? NW + 1 : 1;
      run_op(op, a, b, x, dz, lat, rl);
      n_total++;
      if ({dz, x} !== exp)
        $display("FAIL rand_%0d %s a=%h b=%h: got d=%b x=%h want d=%b x=%h", i, op.name(), a, b, dz, x, exp[NOUT], exp[NOUT-1:0]);
      else n_pass++;
      n_total++;
      if (lat !== exp_lat) $display("FAIL rand_lat_%0d %s: got %0d want %0d", i, op.name(), lat, exp_lat);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_wrap_sat();
    test_div();
    test_div0();
    test_back_to_back();
    test_reset_mid_div();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
